ps2_keymap: RTL and testbench



---
 rtl/vt_pkg.sv | 34 +++
 rtl/ps2_keymap_rom.sv | 51 +++++
 rtl/ps2_keymap.sv | 165 ++++++++++++++++
 tb/tb_ps2_keymap.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/vt_pkg.sv
// rtl/vt_pkg.sv - shared scan-code and ASCII constants for the keyboard/terminal path
// Also holds the keymap state enum used by ps2_keymap.
package vt_pkg;

  localparam logic [7:0] SCAN_EXTENDED = 8'hE0;
  localparam logic [7:0] SCAN_BREAK    = 8'hF0;
  localparam logic [7:0] SCAN_PAUSE    = 8'hE1;
  localparam logic [7:0] SCAN_LSHIFT   = 8'h12;
  localparam logic [7:0] SCAN_RSHIFT   = 8'h59;
  localparam logic [7:0] SCAN_CTRL     = 8'h14;
  localparam logic [7:0] SCAN_CAPS     = 8'h58;
  localparam logic [7:0] SCAN_UP       = 8'h75;
  localparam logic [7:0] SCAN_DOWN     = 8'h72;
  localparam logic [7:0] SCAN_RIGHT    = 8'h74;
  localparam logic [7:0] SCAN_LEFT     = 8'h6B;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_TAB      = 8'h09;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;

  localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK,
    SKIP,
    EMIT
  } keymap_state_t;

endpackage

// File: rtl/ps2_keymap_rom.sv
// rtl/ps2_keymap_rom.sv - US-layout scan set 2 to {plain, shifted} ASCII lookup
// A zero pair means the key has no printable/control mapping.
module keymap_rom
  import vt_pkg::*;
(
  input  logic [7:0] scan_i,
  output logic [7:0] plain_o,
  output logic [7:0] shifted_o
);

  logic [15:0] pair;

  always_comb begin
    pair = 16'h0000;
    case (scan_i)
      8'h1C: pair = 16'h6141;  8'h32: pair = 16'h6242;
      8'h21: pair = 16'h6343;  8'h23: pair = 16'h6444;
      8'h24: pair = 16'h6545;  8'h2B: pair = 16'h6646;
      8'h34: pair = 16'h6747;  8'h33: pair = 16'h6848;
      8'h43: pair = 16'h6949;  8'h3B: pair = 16'h6A4A;
      8'h42: pair = 16'h6B4B;  8'h4B: pair = 16'h6C4C;
      8'h3A: pair = 16'h6D4D;  8'h31: pair = 16'h6E4E;
      8'h44: pair = 16'h6F4F;  8'h4D: pair = 16'h7050;
      8'h15: pair = 16'h7151;  8'h2D: pair = 16'h7252;
      8'h1B: pair = 16'h7353;  8'h2C: pair = 16'h7454;
      8'h3C: pair = 16'h7555;  8'h2A: pair = 16'h7656;
      8'h1D: pair = 16'h7757;  8'h22: pair = 16'h7858;
      8'h35: pair = 16'h7959;  8'h1A: pair = 16'h7A5A;
      8'h16: pair = 16'h3121;  8'h1E: pair = 16'h3240;
      8'h26: pair = 16'h3323;  8'h25: pair = 16'h3424;
      8'h2E: pair = 16'h3525;  8'h36: pair = 16'h365E;
      8'h3D: pair = 16'h3726;  8'h3E: pair = 16'h382A;
      8'h46: pair = 16'h3928;  8'h45: pair = 16'h3029;
      8'h4E: pair = 16'h2D5F;  8'h55: pair = 16'h3D2B;
      8'h54: pair = 16'h5B7B;  8'h5B: pair = 16'h5D7D;
      8'h5D: pair = 16'h5C7C;  8'h4C: pair = 16'h3B3A;
      8'h52: pair = 16'h2722;  8'h41: pair = 16'h2C3C;
      8'h49: pair = 16'h2E3E;  8'h4A: pair = 16'h2F3F;
      8'h0E: pair = 16'h607E;  8'h29: pair = 16'h2020;
      8'h5A: pair = {ASCII_CR, ASCII_CR};
      8'h66: pair = {ASCII_BS, ASCII_BS};
      8'h0D: pair = {ASCII_TAB, ASCII_TAB};
      8'h76: pair = {ASCII_ESC, ASCII_ESC};
      default: pair = 16'h0000;
    endcase
  end

  assign plain_o   = pair[15:8];
  assign shifted_o = pair[7:0];

endmodule

// File: rtl/ps2_keymap.sv
// rtl/ps2_keymap.sv - PS/2 scan set 2 to ASCII/VT byte stream translator
// Tracks prefixes and modifiers; arrows expand to ESC [ A..D.
module ps2_keymap
  import vt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  input  logic       out_ready,
  output logic       caps_lock
);

  keymap_state_t state_q, state_d;
  logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic       ctrl_q, ctrl_d, caps_held_q, caps_held_d, caps_lock_q, caps_lock_d;
  logic [7:0] out_byte_q, out_byte_d, final_q, final_d;
  logic       seq_q, seq_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] skip_q, skip_d;

  logic [7:0] plain, shifted, chosen, mapped;
  logic       is_letter, use_shift, accept;

  keymap_rom u_rom (
    .scan_i    (in_byte),
    .plain_o   (plain),
    .shifted_o (shifted)
  );

  // Caps Lock only inverts Shift for letters; Ctrl folds 40-7F onto control codes.
  assign is_letter = (plain >= 8'h61) && (plain <= 8'h7A);
  assign use_shift = (shift_l_q | shift_r_q) ^ (is_letter & caps_lock_q);
  assign chosen    = use_shift ? shifted : plain;
  assign mapped    = (ctrl_q && chosen[7:6] == 2'b01) ? (chosen & 8'h1F) : chosen;

  assign in_ready  = (state_q != EMIT) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == EMIT);
  assign out_byte  = out_byte_q;
  assign caps_lock = caps_lock_q;

  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    ctrl_d      = ctrl_q;
    caps_held_d = caps_held_q;
    caps_lock_d = caps_lock_q;
    out_byte_d  = out_byte_q;
    final_d     = final_q;
    seq_d       = seq_q;
    idx_d       = idx_q;
    skip_d      = skip_q;

    case (state_q)
      IDLE: if (accept) begin
        case (in_byte)
          SCAN_EXTENDED: state_d = EXT;
          SCAN_BREAK:    state_d = BREAK;
          SCAN_PAUSE: begin
            state_d = SKIP;
            skip_d  = PAUSE_TAIL_LEN;
          end
          8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
          SCAN_LSHIFT: shift_l_d = 1'b1;
          SCAN_RSHIFT: shift_r_d = 1'b1;
          SCAN_CTRL:   ctrl_d    = 1'b1;
          SCAN_CAPS: begin
            if (!caps_held_q) caps_lock_d = ~caps_lock_q;
            caps_held_d = 1'b1;
          end
          default: if (chosen != 8'h00) begin
            out_byte_d = mapped;
            seq_d      = 1'b0;
            state_d    = EMIT;
          end
        endcase
      end
      BREAK: if (accept) begin
        case (in_byte)
          SCAN_LSHIFT: shift_l_d   = 1'b0;
          SCAN_RSHIFT: shift_r_d   = 1'b0;
          SCAN_CTRL:   ctrl_d      = 1'b0;
          SCAN_CAPS:   caps_held_d = 1'b0;
          default: ;
        endcase
        state_d = IDLE;
      end
      EXT: if (accept) begin
        state_d = IDLE;
        case (in_byte)
          SCAN_BREAK: state_d = EXT_BREAK;
          SCAN_CTRL:  ctrl_d  = 1'b1;
          SCAN_UP, SCAN_DOWN, SCAN_RIGHT, SCAN_LEFT: begin
            out_byte_d = ASCII_ESC;
            seq_d      = 1'b1;
            idx_d      = 2'd0;
            state_d    = EMIT;
            case (in_byte)
              SCAN_UP:    final_d = 8'h41;
              SCAN_DOWN:  final_d = 8'h42;
              SCAN_RIGHT: final_d = 8'h43;
              default:    final_d = 8'h44;
            endcase
          end
          default: ;
        endcase
      end
      EXT_BREAK: if (accept) begin
        if (in_byte == SCAN_CTRL) ctrl_d = 1'b0;
        state_d = IDLE;
      end
      SKIP: if (accept) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) state_d = IDLE;
      end
      EMIT: if (out_ready) begin
        if (!seq_q || idx_q == 2'd2) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (idx_q == 2'd0) begin
          out_byte_d = ASCII_LBRACKET;
          idx_d      = 2'd1;
        end else begin
          out_byte_d = final_q;
          idx_d      = 2'd2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
      out_byte_q  <= 8'h00;
      final_q     <= 8'h00;
      seq_q       <= 1'b0;
      idx_q       <= 2'd0;
      skip_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      ctrl_q      <= ctrl_d;
      caps_held_q <= caps_held_d;
      caps_lock_q <= caps_lock_d;
      out_byte_q  <= out_byte_d;
      final_q     <= final_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      skip_q      <= skip_d;
    end
  end

endmodule

// File: tb/tb_ps2_keymap.sv
// tb/tb_ps2_keymap.sv - directed self-checking bench for ps2_keymap
// Inputs change at posedge+1; outputs are checked there, away from the edge.
module tb_ps2_keymap;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;
  logic       caps_lock;

  int checks = 0;
  int errors = 0;

  ps2_keymap dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_ready (out_ready),
    .caps_lock (caps_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 8'h00, 8'h01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_quiet(input logic [7:0] b, input string tag);
    push(b);
    chk(tag, {7'd0, out_valid}, 8'h00);
  endtask

  task automatic cyc(input logic rdy, input logic [7:0] exp, input string tag);
    out_ready = rdy;
    chk(tag, {7'd0, out_valid}, 8'h01);
    chk(tag, out_byte, exp);
    chk(tag, {7'd0, in_ready}, 8'h00);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {7'd0, out_valid}, 8'h00);
    chk(tag, {7'd0, in_ready}, 8'h01);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_in_ready", {7'd0, in_ready}, 8'h00);
    chk("rst_caps", {7'd0, caps_lock}, 8'h00);
    reset = 1'b0;
    #1;
    idle_chk("post_rst");

    // plain and shifted letters
    push(8'h1C);         cyc(1'b1, 8'h61, "plain_a");   idle_chk("plain_a_done");
    push_quiet(8'h12, "lshift");
    push(8'h1C);         cyc(1'b1, 8'h41, "shift_a");   idle_chk("shift_a_done");
    push_quiet(8'hF0, "brk"); push_quiet(8'h12, "lshift_rel");
    push(8'h1C);         cyc(1'b1, 8'h61, "unshift_a"); idle_chk("unshift_a_done");
    push_quiet(8'h59, "rshift");
    push(8'h1E);         cyc(1'b1, 8'h40, "shift_2");
    push_quiet(8'hF0, "brk2"); push_quiet(8'h59, "rshift_rel");

    // caps lock with typematic repeat
    push_quiet(8'h58, "caps1");
    chk("caps_on", {7'd0, caps_lock}, 8'h01);
    push_quiet(8'h58, "caps_rep");
    chk("caps_no_retoggle", {7'd0, caps_lock}, 8'h01);
    push_quiet(8'hF0, "brk3"); push_quiet(8'h58, "caps_rel");
    push(8'h1C);         cyc(1'b1, 8'h41, "caps_a");
    push(8'h16);         cyc(1'b1, 8'h31, "caps_digit");
    push_quiet(8'h12, "lshift2");
    push(8'h1C);         cyc(1'b1, 8'h61, "caps_shift_a");
    push_quiet(8'hF0, "brk4"); push_quiet(8'h12, "lshift2_rel");
    push_quiet(8'h58, "caps2");
    chk("caps_off", {7'd0, caps_lock}, 8'h00);
    push_quiet(8'hF0, "brk5"); push_quiet(8'h58, "caps2_rel");

    // ctrl, left and right
    push_quiet(8'h14, "lctrl");
    push(8'h21);         cyc(1'b1, 8'h03, "ctrl_c");
    push(8'h5A);         cyc(1'b1, 8'h0D, "ctrl_enter");
    push_quiet(8'hF0, "brk6"); push_quiet(8'h14, "lctrl_rel");
    push(8'h21);         cyc(1'b1, 8'h63, "plain_c");
    push_quiet(8'hE0, "ext1"); push_quiet(8'h14, "rctrl");
    push(8'h21);         cyc(1'b1, 8'h03, "rctrl_c");
    push_quiet(8'hE0, "ext2"); push_quiet(8'hF0, "ext_brk"); push_quiet(8'h14, "rctrl_rel");
    push(8'h21);         cyc(1'b1, 8'h63, "rctrl_cleared");

    // arrow up under back-pressure 0,1,0,1,1
    push_quiet(8'hE0, "ext3");
    push(8'h75);
    cyc(1'b0, 8'h1B, "up_esc_stall");
    cyc(1'b1, 8'h1B, "up_esc");
    cyc(1'b0, 8'h5B, "up_brk_stall");
    cyc(1'b1, 8'h5B, "up_brk");
    cyc(1'b1, 8'h41, "up_final");
    idle_chk("up_done");

    // arrow left at full rate
    push_quiet(8'hE0, "ext4");
    push(8'h6B);
    cyc(1'b1, 8'h1B, "left_esc");
    cyc(1'b1, 8'h5B, "left_brk");
    cyc(1'b1, 8'h44, "left_final");
    idle_chk("left_done");

    // noise, pause sequence, unmapped code, fixed mappings
    push_quiet(8'hAA, "noise_aa"); push_quiet(8'hFA, "noise_fa");
    push_quiet(8'hE1, "p0"); push_quiet(8'h14, "p1"); push_quiet(8'h77, "p2");
    push_quiet(8'hE1, "p3"); push_quiet(8'hF0, "p4"); push_quiet(8'h14, "p5");
    push_quiet(8'hF0, "p6"); push_quiet(8'h77, "p7");
    push_quiet(8'h05, "unmapped");
    push(8'h5A);         cyc(1'b1, 8'h0D, "enter");
    push(8'h21);         cyc(1'b1, 8'h63, "after_pause_c");
    push(8'h66);         cyc(1'b1, 8'h08, "bksp");

    // reset in the middle of an arrow sequence
    push_quiet(8'hE0, "ext5");
    push(8'h75);
    cyc(1'b1, 8'h1B, "rst_seq_esc");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_valid", {7'd0, out_valid}, 8'h00);
    chk("midrst_byte", out_byte, 8'h00);
    push(8'h1C);         cyc(1'b1, 8'h61, "after_rst_a");
    idle_chk("after_rst_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
